// File: rtl/idli_pkg.sv
// Shared types and constants for the idli decode stage.
//
// Contents:
//   op_t, reg_t, data_t, ctr_t  - field and bus types
//   dec_state_t                 - decode FSM state (IDLE / WAIT_IMM)
//   DEC_IMM_REG_DEFAULT         - rb encoding that announces a trailing immediate
//   DEC_IMM_OP_MASK_DEFAULT     - opcodes that may take an immediate
//   *_MSB / *_LSB               - instruction field slice positions
//   dec_needs_imm()             - immediate-need check for one instruction word
package idli_pkg;

  typedef logic [3:0]  op_t;
  typedef logic [3:0]  reg_t;
  typedef logic [15:0] data_t;
  typedef logic [1:0]  ctr_t;

  typedef enum logic {
    DEC_IDLE     = 1'b0,
    DEC_WAIT_IMM = 1'b1
  } dec_state_t;

  localparam logic [3:0]  DEC_IMM_REG_DEFAULT     = 4'hF;
  localparam logic [15:0] DEC_IMM_OP_MASK_DEFAULT = 16'h00FF;

  localparam int OP_MSB = 15;
  localparam int OP_LSB = 12;
  localparam int RD_MSB = 11;
  localparam int RD_LSB = 8;
  localparam int RA_MSB = 7;
  localparam int RA_LSB = 4;
  localparam int RB_MSB = 3;
  localparam int RB_LSB = 0;

  // A word is the first half of a two-word op when its opcode is enabled in
  // the mask and its rb field carries the "immediate follows" encoding.
  function automatic logic dec_needs_imm(input data_t      word,
                                         input logic [15:0] op_mask,
                                         input reg_t       imm_reg);
    return op_mask[word[OP_MSB:OP_LSB]] && (word[RB_MSB:RB_LSB] == imm_reg);
  endfunction

endpackage

// File: rtl/idli_dec_skid_m.sv
// One-entry word skid buffer.
//
// Holds a single 16b word while the consumer is busy. Control inputs are
// expected to be pre-qualified by the caller (e.g. with a phase tick).
//
// Ports:
//   clk    in   1   clock
//   rst_n  in   1   synchronous active-low reset
//   clr    in   1   discard the held word (highest priority after reset)
//   push   in   1   capture din; only issued while empty
//   pop    in   1   release the held word
//   din    in   16  word to capture
//   dout   out 16   held word (valid while full)
//   full   out  1   entry occupied (flopped)
module idli_dec_skid_m
  import idli_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        push,
  input  logic        pop,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        full
);

  data_t data_q;
  logic  full_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else if (clr) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else if (push) begin
      data_q <= din;
      full_q <= 1'b1;
    end else if (pop) begin
      full_q <= 1'b0;
    end
  end

  assign dout = data_q;
  assign full = full_q;

endmodule

// File: rtl/idli_dec_m.sv
// idli decode stage: sits directly behind the SQI memory interface.
//
// Splits each 16b instruction word into op/rd/ra/rb, merges a trailing
// immediate word into the preceding op, and presents one decoded op to
// execute. State only moves on a "tick" (GCK cycle with i_dec_ctr == 2'b11).
//
// Handshake: o_dec_vld is a registered valid; execute takes the op on a tick
// where o_dec_vld && i_dec_ex_rdy. While o_dec_vld && !i_dec_ex_rdy every
// output field is held stable. Upstream back-pressure is o_dec_stall, which
// is high exactly while the skid entry holds a word; SQI must not present a
// new word on a tick while stalled.
//
// Optional build macro: IDLI_DEC_COUNT_EN adds o_dec_count, a wrapping count
// of accepted ops (not cleared by redirect).
//
// Ports:
//   i_dec_gck        in   1   core clock
//   i_dec_rst_n      in   1   synchronous active-low reset
//   i_dec_ctr        in   2   4-GCK phase counter; tick when both bits set
//   i_dec_redirect   in   1   flush, sampled at a tick
//   i_dec_instr      in   16  instruction word [15:12] op [11:8] rd [7:4] ra [3:0] rb
//   i_dec_instr_vld  in   1   word valid at a tick
//   i_dec_ex_rdy     in   1   execute accepts the current op at this tick
//   o_dec_vld        out  1   decoded op valid
//   o_dec_op         out  4   opcode
//   o_dec_rd/ra/rb   out  4   register fields
//   o_dec_imm_vld    out  1   op carries an immediate
//   o_dec_imm        out  16  immediate word (0 when no immediate)
//   o_dec_stall      out  1   SQI stall, skid occupied
//   o_dec_state      out  1   debug view of the decode FSM (dec_state_t)
//   o_dec_count      out  16  accepted-op count (IDLI_DEC_COUNT_EN only)
module idli_dec_m
  import idli_pkg::*;
#(
  parameter logic [15:0] IMM_OP_MASK = DEC_IMM_OP_MASK_DEFAULT,
  parameter logic [3:0]  IMM_REG     = DEC_IMM_REG_DEFAULT
) (
  input  logic        i_dec_gck,
  input  logic        i_dec_rst_n,
  input  logic [1:0]  i_dec_ctr,
  input  logic        i_dec_redirect,
  input  logic [15:0] i_dec_instr,
  input  logic        i_dec_instr_vld,
  input  logic        i_dec_ex_rdy,
  output logic        o_dec_vld,
  output logic [3:0]  o_dec_op,
  output logic [3:0]  o_dec_rd,
  output logic [3:0]  o_dec_ra,
  output logic [3:0]  o_dec_rb,
  output logic        o_dec_imm_vld,
  output logic [15:0] o_dec_imm,
  output logic        o_dec_stall,
  output logic        o_dec_state
`ifdef IDLI_DEC_COUNT_EN
  ,
  output logic [15:0] o_dec_count
`endif
);

  // ---------------------------------------------------------------------------
  // Tick qualification and handshake terms
  // ---------------------------------------------------------------------------
  logic tick;
  logic accept;
  logic out_free;

  assign tick     = &i_dec_ctr;
  assign accept   = o_dec_vld && i_dec_ex_rdy;
  // Output register can take a new op if empty or being drained this tick.
  assign out_free = !o_dec_vld || i_dec_ex_rdy;

  // ---------------------------------------------------------------------------
  // Skid entry
  // ---------------------------------------------------------------------------
  logic  skid_full;
  data_t skid_dout;
  logic  skid_push;
  logic  skid_pop;
  logic  skid_clr;

  // The skid is older than anything on the bus, so it is always drained first.
  logic  src_vld;
  data_t src_word;
  logic  consume;

  assign src_vld  = skid_full || i_dec_instr_vld;
  assign src_word = skid_full ? skid_dout : i_dec_instr;
  assign consume  = tick && !i_dec_redirect && src_vld && out_free;

  assign skid_clr  = tick && i_dec_redirect;
  assign skid_pop  = consume && skid_full;
  // A word arriving while the skid is already full is a protocol violation
  // and is dropped here (never pushed over the held word).
  assign skid_push = tick && !i_dec_redirect && !skid_full && i_dec_instr_vld && !out_free;

  idli_dec_skid_m u_skid (
    .clk   (i_dec_gck),
    .rst_n (i_dec_rst_n),
    .clr   (skid_clr),
    .push  (skid_push),
    .pop   (skid_pop),
    .din   (i_dec_instr),
    .dout  (skid_dout),
    .full  (skid_full)
  );

  // ---------------------------------------------------------------------------
  // Field split of the source word
  // ---------------------------------------------------------------------------
  op_t  src_op;
  reg_t src_rd;
  reg_t src_ra;
  reg_t src_rb;
  logic src_need_imm;

  assign src_op       = src_word[OP_MSB:OP_LSB];
  assign src_rd       = src_word[RD_MSB:RD_LSB];
  assign src_ra       = src_word[RA_MSB:RA_LSB];
  assign src_rb       = src_word[RB_MSB:RB_LSB];
  assign src_need_imm = dec_needs_imm(src_word, IMM_OP_MASK, IMM_REG);

  // ---------------------------------------------------------------------------
  // Decode FSM
  // ---------------------------------------------------------------------------
  dec_state_t state_q;
  dec_state_t state_d;
  data_t      pend_q;
  logic       load_plain;
  logic       load_imm;
  logic       latch_pend;

  always_comb begin
    state_d    = state_q;
    load_plain = 1'b0;
    load_imm   = 1'b0;
    latch_pend = 1'b0;
    if (tick) begin
      if (i_dec_redirect) begin
        state_d = DEC_IDLE;
      end else if (consume) begin
        case (state_q)
          DEC_IDLE: begin
            if (src_need_imm) begin
              latch_pend = 1'b1;
              state_d    = DEC_WAIT_IMM;
            end else begin
              load_plain = 1'b1;
            end
          end
          DEC_WAIT_IMM: begin
            load_imm = 1'b1;
            state_d  = DEC_IDLE;
          end
          default: state_d = DEC_IDLE;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State, pending word and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_dec_gck) begin
    if (!i_dec_rst_n) begin
      state_q       <= DEC_IDLE;
      pend_q        <= '0;
      o_dec_vld     <= 1'b0;
      o_dec_op      <= '0;
      o_dec_rd      <= '0;
      o_dec_ra      <= '0;
      o_dec_rb      <= '0;
      o_dec_imm_vld <= 1'b0;
      o_dec_imm     <= '0;
    end else begin
      state_q <= state_d;
      if (tick && i_dec_redirect) begin
        pend_q        <= '0;
        o_dec_vld     <= 1'b0;
        o_dec_imm_vld <= 1'b0;
        o_dec_imm     <= '0;
      end else begin
        if (latch_pend) begin
          pend_q <= src_word;
        end
        if (load_plain) begin
          o_dec_vld     <= 1'b1;
          o_dec_op      <= src_op;
          o_dec_rd      <= src_rd;
          o_dec_ra      <= src_ra;
          o_dec_rb      <= src_rb;
          o_dec_imm_vld <= 1'b0;
          o_dec_imm     <= '0;
        end else if (load_imm) begin
          o_dec_vld     <= 1'b1;
          o_dec_op      <= pend_q[OP_MSB:OP_LSB];
          o_dec_rd      <= pend_q[RD_MSB:RD_LSB];
          o_dec_ra      <= pend_q[RA_MSB:RA_LSB];
          o_dec_rb      <= pend_q[RB_MSB:RB_LSB];
          o_dec_imm_vld <= 1'b1;
          o_dec_imm     <= src_word;
        end else if (tick && accept) begin
          // Drained with nothing behind it (includes the tick that only
          // captures the first half of an immediate op).
          o_dec_vld <= 1'b0;
        end
      end
    end
  end

  assign o_dec_stall = skid_full;
  assign o_dec_state = state_q;

`ifdef IDLI_DEC_COUNT_EN
  logic [15:0] count_q;

  always_ff @(posedge i_dec_gck) begin
    if (!i_dec_rst_n) begin
      count_q <= '0;
    end else if (tick && accept && !i_dec_redirect) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign o_dec_count = count_q;
`endif

  // SQI is stalled while the skid is full, so a word at such a tick is illegal.
  a_no_word_while_stalled: assert property (
    @(posedge i_dec_gck) disable iff (!i_dec_rst_n)
      !(tick && !i_dec_redirect && skid_full && i_dec_instr_vld));

endmodule

// File: tb/tb_idli_dec_m.sv
// Testbench for idli_dec_m: directed cases followed by randomized traffic,
// checked by a scoreboard fed from a word-stream reference model.
module tb_idli_dec_m;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  ctr = 2'b00;
  logic        redirect = 1'b0;
  logic [15:0] instr = 16'h0;
  logic        instr_vld = 1'b0;
  logic        ex_rdy = 1'b0;

  logic        o_dec_vld;
  logic [3:0]  o_dec_op;
  logic [3:0]  o_dec_rd;
  logic [3:0]  o_dec_ra;
  logic [3:0]  o_dec_rb;
  logic        o_dec_imm_vld;
  logic [15:0] o_dec_imm;
  logic        o_dec_stall;
  logic        o_dec_state;
`ifdef IDLI_DEC_COUNT_EN
  logic [15:0] o_dec_count;
`endif

  always #5 clk = ~clk;

  idli_dec_m dut (
    .i_dec_gck       (clk),
    .i_dec_rst_n     (rst_n),
    .i_dec_ctr       (ctr),
    .i_dec_redirect  (redirect),
    .i_dec_instr     (instr),
    .i_dec_instr_vld (instr_vld),
    .i_dec_ex_rdy    (ex_rdy),
    .o_dec_vld       (o_dec_vld),
    .o_dec_op        (o_dec_op),
    .o_dec_rd        (o_dec_rd),
    .o_dec_ra        (o_dec_ra),
    .o_dec_rb        (o_dec_rb),
    .o_dec_imm_vld   (o_dec_imm_vld),
    .o_dec_imm       (o_dec_imm),
    .o_dec_stall     (o_dec_stall),
    .o_dec_state     (o_dec_state)
`ifdef IDLI_DEC_COUNT_EN
    ,
    .o_dec_count     (o_dec_count)
`endif
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state and reference model
  // ---------------------------------------------------------------------------
  // Expected op packed as {op, rd, ra, rb, imm_vld, imm}.
  logic [32:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        has_partial = 1'b0;
  logic [15:0] partial_word = 16'h0;
  logic [15:0] acc_count = 16'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Opcodes 0..7 with rb == F announce a trailing immediate word.
  function automatic logic model_needs_imm(input logic [15:0] w);
    return (w[15:12] < 4'd8) && (w[3:0] == 4'hF);
  endfunction

  // Every word the decoder really receives, in order, is grouped into ops.
  task automatic model_word(input logic [15:0] w);
    if (has_partial) begin
      exp_q.push_back({partial_word, 1'b1, w});
      has_partial = 1'b0;
    end else if (model_needs_imm(w)) begin
      partial_word = w;
      has_partial  = 1'b1;
    end else begin
      exp_q.push_back({w, 1'b0, 16'h0});
    end
  endtask

  // A flush loses everything not yet taken by execute.
  task automatic model_flush();
    exp_q.delete();
    has_partial = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // One 4-GCK phase: three non-tick cycles with junk inputs, then the tick.
  task automatic tick(input logic v, input logic [15:0] w, input logic rdy, input logic redir);
    for (int p = 0; p < 3; p++) begin
      ctr       = 2'(p);
      instr_vld = 1'($urandom_range(0, 1));
      instr     = 16'($urandom);
      ex_rdy    = 1'($urandom_range(0, 1));
      redirect  = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    ctr       = 2'b11;
    instr_vld = v;
    instr     = w;
    ex_rdy    = rdy;
    redirect  = redir;
    if (redir) model_flush();
    else if (v) model_word(w);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ctr       = 2'(i);
      instr_vld = 1'b1;
      instr     = 16'($urandom);
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    model_flush();
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: pops an expectation whenever execute takes an op
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (rst_n && ctr == 2'b11 && o_dec_vld && ex_rdy && !redirect) begin
      logic [32:0] act;
      logic [32:0] exp;
      act = {o_dec_op, o_dec_rd, o_dec_ra, o_dec_rb, o_dec_imm_vld, o_dec_imm};
      acc_count = acc_count + 16'd1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got %0h expected no op", act);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          errors++;
          $display("FAIL sb_op: got %0h expected %0h", act, exp);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    #4000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        v;
    logic [15:0] w;
    int          guard;

    @(posedge clk); #1;
    do_reset();

    // Reset state
    chk("rst_vld", o_dec_vld, 0);
    chk("rst_stall", o_dec_stall, 0);
    chk("rst_fields", {o_dec_op, o_dec_rd, o_dec_ra, o_dec_rb}, 0);
    chk("rst_imm", {o_dec_imm_vld, o_dec_imm}, 0);
    chk("rst_state", o_dec_state, 0);

    // Plain op
    tick(1, 16'h1234, 1, 0);
    chk("plain_vld", o_dec_vld, 1);
    chk("plain_fields", {o_dec_op, o_dec_rd, o_dec_ra, o_dec_rb, o_dec_imm_vld}, {16'h1234, 1'b0});
    chk("plain_stall", o_dec_stall, 0);
    tick(0, 16'h0, 1, 0);

    // Two-word immediate op
    tick(1, 16'h312F, 1, 0);
    chk("imm_first_novld", o_dec_vld, 0);
    chk("imm_first_state", o_dec_state, 1);
    tick(1, 16'hBEEF, 1, 0);
    chk("imm_vld", o_dec_vld, 1);
    chk("imm_op", {o_dec_op, o_dec_rd, o_dec_ra, o_dec_rb}, 16'h312F);
    chk("imm_word", {o_dec_imm_vld, o_dec_imm}, {1'b1, 16'hBEEF});
    chk("imm_state_idle", o_dec_state, 0);
    tick(0, 16'h0, 1, 0);

    // rb == F on an opcode outside the mask is an ordinary op
    tick(1, 16'h912F, 1, 0);
    chk("nomask_vld", o_dec_vld, 1);
    chk("nomask_immvld", o_dec_imm_vld, 0);
    tick(1, 16'h1234, 1, 0);
    chk("nomask_next_op", {o_dec_vld, o_dec_op, o_dec_imm_vld}, {1'b1, 4'h1, 1'b0});
    tick(0, 16'h0, 1, 0);

    // Back-pressure fills the skid, then drains
    tick(1, 16'h1234, 0, 0);
    tick(1, 16'h5678, 0, 0);
    chk("skid_stall", o_dec_stall, 1);
    chk("skid_hold", {o_dec_vld, o_dec_op, o_dec_rd, o_dec_ra, o_dec_rb}, {1'b1, 16'h1234});
    tick(0, 16'h0, 1, 0);
    chk("skid_drain", {o_dec_vld, o_dec_op, o_dec_rd, o_dec_ra, o_dec_rb}, {1'b1, 16'h5678});
    chk("skid_stall_drop", o_dec_stall, 0);
    tick(0, 16'h0, 1, 0);

    // Redirect in the middle of a pair
    tick(1, 16'h312F, 1, 0);
    tick(1, 16'hABCD, 1, 1);
    chk("redir_novld", o_dec_vld, 0);
    chk("redir_state", o_dec_state, 0);
    tick(1, 16'h1111, 1, 0);
    chk("redir_next", {o_dec_vld, o_dec_op, o_dec_rd, o_dec_ra, o_dec_rb, o_dec_imm_vld},
        {1'b1, 16'h1111, 1'b0});
    tick(0, 16'h0, 1, 0);

    // Redirect while an op is stalled in the output and another in the skid
    tick(1, 16'h2345, 0, 0);
    tick(1, 16'h3456, 0, 0);
    tick(0, 16'h0, 1, 1);
    chk("redir_flush", {o_dec_vld, o_dec_stall}, 0);

    // Reset in the middle of a pair
    tick(1, 16'h312F, 1, 0);
    do_reset();
    chk("rst_mid_state", {o_dec_state, o_dec_vld}, 0);
    tick(1, 16'h1111, 1, 0);
    chk("rst_mid_next", {o_dec_vld, o_dec_imm_vld, o_dec_op}, {1'b1, 1'b0, 4'h1});
    tick(0, 16'h0, 1, 0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      v = ($urandom_range(0, 9) < 6) && !o_dec_stall;
      if ($urandom_range(0, 9) < 4)
        w = {1'b0, 3'($urandom_range(0, 7)), 8'($urandom), 4'hF};
      else
        w = 16'($urandom);
      tick(v, w, ($urandom_range(0, 9) < 7), ($urandom_range(0, 29) == 0));
    end

    // Drain: finish any half op with a filler immediate, then empty the pipe
    if (has_partial) tick(1, 16'h0F0F, 1, 0);
    guard = 0;
    while ((exp_q.size() != 0 || o_dec_vld) && guard < 40) begin
      tick(0, 16'h0, 1, 0);
      guard++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
    chk("drain_idle", {o_dec_vld, o_dec_stall}, 0);
`ifdef IDLI_DEC_COUNT_EN
    chk("count", o_dec_count, acc_count);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
